// File: rtl/qr_inverse_iter.sv
// ============================================================================
// Module   : qr_inverse_iter
// Purpose  : Iterative ChaCha20 inverse quarter-round engine, one ARX step per
//            clock. Optional forward mode via macro QR_INV_BIDIR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qr_inverse_iter #(
    parameter int ITER_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic [31:0]       in_c,
    input  logic [31:0]       in_d,
    input  logic [ITER_W-1:0] in_count,
`ifdef QR_INV_BIDIR_EN
    input  logic              mode,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_a,
    output logic [31:0]       out_b,
    output logic [31:0]       out_c,
    output logic [31:0]       out_d,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_a, r_b, r_c, r_d;
    logic [31:0]         w_a, w_b, w_c, w_d;
    logic [ITER_W-1:0]   r_iter;
    logic [1:0]          r_step;
    logic                w_accept;
    logic                w_last;
`ifdef QR_INV_BIDIR_EN
    logic                r_fwd;
    logic [31:0]         w_sum_a;
    logic [31:0]         w_sum_c;
`endif

    // in_ready is gated by rst so it reads 0 for the whole reset pulse.
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign out_a     = r_a;
    assign out_b     = r_b;
    assign out_c     = r_c;
    assign out_d     = r_d;

    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_step == 2'd3) && (r_iter == ITER_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (in_count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef QR_INV_BIDIR_EN
    assign w_sum_a = r_a + r_b;
    assign w_sum_c = r_c + r_d;
`endif

    // One ARX step; each step reads the words already updated by the previous one.
    always_comb begin
        w_a = r_a;
        w_b = r_b;
        w_c = r_c;
        w_d = r_d;
`ifdef QR_INV_BIDIR_EN
        if (r_fwd) begin
            case (r_step)
                2'd0: begin
                    w_a = w_sum_a;
                    w_d = {r_d[15:0] ^ w_sum_a[15:0], r_d[31:16] ^ w_sum_a[31:16]};
                end
                2'd1: begin
                    w_c = w_sum_c;
                    w_b = {r_b[19:0] ^ w_sum_c[19:0], r_b[31:20] ^ w_sum_c[31:20]};
                end
                2'd2: begin
                    w_a = w_sum_a;
                    w_d = {r_d[23:0] ^ w_sum_a[23:0], r_d[31:24] ^ w_sum_a[31:24]};
                end
                default: begin
                    w_c = w_sum_c;
                    w_b = {r_b[24:0] ^ w_sum_c[24:0], r_b[31:25] ^ w_sum_c[31:25]};
                end
            endcase
        end else begin
`endif
            case (r_step)
                2'd0: begin
                    w_b = {r_b[6:0], r_b[31:7]} ^ r_c;
                    w_c = r_c - r_d;
                end
                2'd1: begin
                    w_d = {r_d[7:0], r_d[31:8]} ^ r_a;
                    w_a = r_a - r_b;
                end
                2'd2: begin
                    w_b = {r_b[11:0], r_b[31:12]} ^ r_c;
                    w_c = r_c - r_d;
                end
                default: begin
                    w_d = {r_d[15:0], r_d[31:16]} ^ r_a;
                    w_a = r_a - r_b;
                end
            endcase
`ifdef QR_INV_BIDIR_EN
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= '0;
            r_d    <= '0;
            r_iter <= '0;
            r_step <= '0;
`ifdef QR_INV_BIDIR_EN
            r_fwd  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a    <= in_a;
                        r_b    <= in_b;
                        r_c    <= in_c;
                        r_d    <= in_d;
                        r_iter <= in_count;
                        r_step <= 2'd0;
`ifdef QR_INV_BIDIR_EN
                        r_fwd  <= mode;
`endif
                    end
                end
                S_RUN: begin
                    r_a    <= w_a;
                    r_b    <= w_b;
                    r_c    <= w_c;
                    r_d    <= w_d;
                    r_step <= r_step + 2'd1;
                    if (r_step == 2'd3) begin
                        r_iter <= r_iter - ITER_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire
